// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: multi-cycle WIDTH-bit adder that time-multiplexes a shared 2-bit ripple-carry slice
module adder_slice_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [1:0]       adder_in_1,
  output logic [1:0]       adder_in_2,
  output logic             adder_c_in,
  input  logic [1:0]       adder_sum,
  input  logic             adder_c_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int NSLICE = WIDTH / 2;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW:0] idx;
  logic run;
  assign idx = {k_q, 1'b0};
  assign run = state_q == RUN;
  assign start_ready = state_q == IDLE;
  assign res_valid = state_q == DONE;
  assign adder_in_1 = run ? a_q[idx +: 2] : 2'b00;
  assign adder_in_2 = run ? b_q[idx +: 2] : 2'b00;
  assign adder_c_in = run ? carry_q : 1'b0;
  assign result = res_q;
  assign cout = cout_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    carry_d = carry_q;
    cout_d = cout_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (start_valid) begin
        a_d = op_a;
        b_d = op_b;
        carry_d = cin;
        k_d = '0;
        res_d = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[idx +: 2] = adder_sum;
        carry_d = adder_c_out;
        k_d = k_q + 1'b1;
        if (k_q == CW'(NSLICE - 1)) begin
          cout_d = adder_c_out;
          state_d = DONE;
        end
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      k_q <= k_d;
    end
  end
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// tb_adder_slice_sequencer: directed self-checking bench with a behavioural 2-bit adder slice
module tb_adder_slice_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_valid = 1'b0, start_ready;
  logic [7:0] op_a = '0, op_b = '0;
  logic cin = 1'b0;
  logic [1:0] adder_in_1, adder_in_2, adder_sum;
  logic adder_c_in, adder_c_out;
  logic res_valid, res_ready = 1'b0;
  logic [7:0] result;
  logic cout;
  int checks = 0, fails = 0;
  logic [1:0] in1_seq [4];
  logic cin_seq [4];
  always #5 clk = ~clk;
  assign {adder_c_out, adder_sum} = 3'(adder_in_1) + 3'(adder_in_2) + 3'(adder_c_in);
  adder_slice_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .adder_in_1(adder_in_1), .adder_in_2(adder_in_2),
    .adder_c_in(adder_c_in), .adder_sum(adder_sum), .adder_c_out(adder_c_out),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .cout(cout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sr"}, start_ready, 1);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_res"}, result, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_adin"}, {adder_in_1, adder_in_2, adder_c_in}, 0);
  endtask
  // Accept one op, scramble the requester inputs, record the four RUN slices, stop in DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    chk("acc_sr", start_ready, 1);
    op_a = a;
    op_b = b;
    cin = ci;
    start_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = ~a;
    op_b = ~b;
    cin = ~ci;
    for (int i = 0; i < 4; i++) begin
      in1_seq[i] = adder_in_1;
      cin_seq[i] = adder_c_in;
      chk("run_rv", res_valid, 0);
      chk("run_sr", start_ready, 0);
      @(negedge clk);
    end
  endtask
  task automatic finish_op(input logic [7:0] r, input logic c);
    chk("done_rv", res_valid, 1);
    chk("done_res", result, r);
    chk("done_cout", cout, c);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_rv", res_valid, 0);
    chk("post_sr", start_ready, 1);
  endtask
  initial begin
    int t1, t2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    run_op(8'h5A, 8'h3C, 1'b0);
    finish_op(8'h96, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    chk("cin_seq", {cin_seq[0], cin_seq[1], cin_seq[2], cin_seq[3]}, 4'b0111);
    finish_op(8'h00, 1'b1);
    run_op(8'hB4, 8'h00, 1'b1);
    chk("in1_seq", {in1_seq[0], in1_seq[1], in1_seq[2], in1_seq[3]}, 8'b00_01_11_10);
    finish_op(8'hB5, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    start_valid = 1'b1;
    op_a = 8'h11;
    op_b = 8'h22;
    cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_res", result, 8'h30);
      chk("bp_rv", res_valid, 1);
      chk("bp_sr", start_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_idle_sr", start_ready, 1);
    chk("bp_idle_rv", res_valid, 0);
    @(negedge clk);
    start_valid = 1'b0;
    chk("bp_new_sr", start_ready, 0);
    chk("bp_new_in1", adder_in_1, 2'b01);
    repeat (4) @(negedge clk);
    finish_op(8'h33, 1'b0);
    @(negedge clk);
    op_a = 8'hAA;
    op_b = 8'h55;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("abort_rv", res_valid, 0);
      @(negedge clk);
    end
    run_op(8'h01, 8'h01, 1'b0);
    finish_op(8'h02, 1'b0);
    op_a = 8'h80;
    op_b = 8'h80;
    cin = 1'b0;
    res_ready = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 8'h7F;
    op_b = 8'h01;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 20 && t2 < 0; i++) begin
      if (res_valid) begin
        if (t1 < 0) begin
          t1 = i;
          chk("b2b_res1", result, 8'h00);
          chk("b2b_cout1", cout, 1);
        end else begin
          t2 = i;
          chk("b2b_res2", result, 8'h80);
          chk("b2b_cout2", cout, 0);
        end
      end
      @(negedge clk);
    end
    start_valid = 1'b0;
    chk("b2b_lat", t1, 4);
    chk("b2b_gap", t2 - t1, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
